serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 162 ++++++++++++++++
 tb/tb_serial_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder built from two half adders plus an OR gate (one full-adder
//   cell) with a carry flip-flop closing the loop. Operands are captured on an
//   accepted start and summed one bit per clock, LSB first. The registered
//   result and carry-out are published together with a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, only sampled in IDLE or DONE
//   sub    (SERIAL_ADDER_SUB_EN only) 1 = compute a - b
//   a, b   operands, captured on an accepted start
//   busy   high in LOAD and SHIFT
//   done   one-cycle pulse, sum/cout valid
//   sum    registered result, held until the next completion
//   cout   registered carry-out of the MSB (for subtract: 1 = no borrow)
//
// Configuration
//   SERIAL_ADDER_SUB_EN  when defined, adds the sub port; b is inverted and the
//                        carry starts at 1 so the datapath computes a - b.
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must reach WIDTH-1; one extra value of headroom keeps the
  // increment on the final shift from wrapping.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] resShift_q, resShift_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] bCapture;
  logic             carryInit;
  logic             ha0Sum, ha0Carry, ha1Sum, ha1Carry, carryNext;

  // Operand conditioning at capture time. Subtraction is a + ~b + 1, so the
  // inversion and the +1 (carry seed) are applied once when the operands load.
`ifdef SERIAL_ADDER_SUB_EN
  assign bCapture  = sub ? ~b : b;
  assign carryInit = sub;
`else
  assign bCapture  = b;
  assign carryInit = 1'b0;
`endif

  // Full-adder cell: first half adder on the operand bits, second half adder
  // folds in the stored carry, OR merges the two partial carries.
  assign ha0Sum    = aShift_q[0] ^ bShift_q[0];
  assign ha0Carry  = aShift_q[0] & bShift_q[0];
  assign ha1Sum    = ha0Sum ^ carry_q;
  assign ha1Carry  = ha0Sum & carry_q;
  assign carryNext = ha0Carry | ha1Carry;

  // State and datapath registers; reset discards any in-flight addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      resShift_q <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      resShift_q <= resShift_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

  // Next-state and datapath updates. start is honoured in IDLE and DONE only,
  // so a start held through DONE chains straight into the next LOAD.
  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    resShift_d = resShift_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    cout_d     = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          aShift_d = a;
          bShift_d = bCapture;
          carry_d  = carryInit;
          cnt_d    = '0;
          state_d  = LOAD;
        end else begin
          state_d  = IDLE;
        end
      end

      LOAD: begin
        state_d = SHIFT;
      end

      SHIFT: begin
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        resShift_d = {ha1Sum, resShift_q[WIDTH-1:1]};
        carry_d    = carryNext;
        cnt_d      = cnt_q + CW'(1);
        // Last bit: publish the fully shifted result, including this bit.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = {ha1Sum, resShift_q[WIDTH-1:1]};
          cout_d  = carryNext;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder at WIDTH=8. Expected results are
//   hand-computed constants. Inputs are driven and outputs sampled on the
//   falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W   = 8;
  localparam int LAT = W + 1;   // edges from the accepting edge to the done cycle
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int testCount = 0;
  int failCount = 0;
  int edgeCount = 0;
  int startEdge = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Absolute edge count, used to measure latency from the accepting edge.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present operands and pulse start for exactly one rising edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic subv);
    @(negedge clk);
    a     = av;
    b     = bv;
    sub   = subv;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    startEdge = edgeCount;
  endtask

  // Wait (bounded) for done, then check latency, result and that sum held
  // its previous value until the done cycle.
  task automatic expectResult(input string tag, input logic [W-1:0] expSum,
                              input logic expCout);
    logic [W-1:0] sumBefore;
    logic         stable;
    sumBefore = sum;
    stable    = 1'b1;
    while (!done && (edgeCount - startEdge) < TMO) begin
      @(negedge clk);
      if (!done && sum !== sumBefore) stable = 1'b0;
    end
    checkOutput({tag, " latency"}, 32'(edgeCount - startEdge), 32'(LAT));
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, " sumHeld"}, 32'(stable), 32'd1);
  endtask

  // Count done pulses over a window of cycles.
  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    // Reset held over two rising edges.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'h00);
    checkOutput("reset cout", 32'(cout), 32'd0);

    // Basic add, then confirm done is a single-cycle pulse and sum holds.
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    checkOutput("basic busyInLoad", 32'(busy), 32'd1);
    expectResult("basic", 8'h96, 1'b0);
    @(negedge clk);
    checkOutput("basic donePulse", 32'(done), 32'd0);
    checkOutput("basic sumHold", 32'(sum), 32'h96);

    // Wrap-around cases.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    expectResult("wrap1", 8'h00, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    expectResult("wrap2", 8'hFE, 1'b1);

    // start pulsed while busy must be ignored (new operands must not load).
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expectResult("ignored", 8'h46, 1'b0);
    countDone(12, pulses);
    checkOutput("ignored extraDone", 32'(pulses), 32'd0);
    checkOutput("ignored idleBusy", 32'(busy), 32'd0);

    // Back-to-back: start held high through DONE chains with no IDLE cycle.
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    @(negedge clk);
    startEdge = edgeCount;
    expectResult("b2b first", 8'h03, 1'b0);
    a = 8'h20;
    b = 8'h22;
    @(negedge clk);
    checkOutput("b2b noIdle", 32'(busy), 32'd1);
    start     = 1'b0;
    startEdge = edgeCount;
    expectResult("b2b second", 8'h42, 1'b0);

    // Reset in the fourth SHIFT cycle discards the operation.
    applyStimulus(8'h80, 8'h80, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst sum", 32'(sum), 32'h00);
    checkOutput("midrst cout", 32'(cout), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    countDone(15, pulses);
    checkOutput("midrst noDone", 32'(pulses), 32'd0);
    applyStimulus(8'h80, 8'h81, 1'b0);
    expectResult("afterRst", 8'h01, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract mode: cout=1 means no borrow.
    applyStimulus(8'h10, 8'h01, 1'b1);
    expectResult("sub1", 8'h0F, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b1);
    expectResult("sub2", 8'hFF, 1'b0);
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    expectResult("sub0add", 8'h96, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
